key_ctrl: RTL and testbench

Push-button front end for the LED blink path. It synchronises and debounces one active-low board key. It classifies each press as short or long, and drives the enable and rate-select inputs of the downstream LED blink counter. The blink counter toggles its LED when its terminal count is reached; this block decides whether it runs and which terminal count it uses.

---
 rtl/key_ctrl_if.sv | 20 ++
 rtl/key_ctrl.sv | 128 ++++++++++++
 tb/tb_key_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_ctrl_if.sv
// Purpose: key_ctrl output bundle to the LED blink path (debounced key state, pulses, blink controls).
// Latency: carries registered outputs only, so it adds no latency.
// Backpressure: none; pulses last one cycle and the consumer must sample them every cycle.
// Signals: key_level, key_press, key_release, key_long (1 bit each); blink_en (1 bit); rate_sel (2 bits).
interface key_ctrl_if;
  logic       key_level;
  logic       key_press;
  logic       key_release;
  logic       key_long;
  logic       blink_en;
  logic [1:0] rate_sel;

  // master: key_ctrl drives the bundle; slave: blink counter / observers read it.
  modport master (
    output key_level, key_press, key_release, key_long, blink_en, rate_sel
  );
  modport slave (
    input key_level, key_press, key_release, key_long, blink_en, rate_sel
  );
endinterface

// File: rtl/key_ctrl.sv
// Purpose: synchronise and debounce one active-low key, classify presses as short or long, drive blink_en and rate_sel.
// Latency: level and pulses change DEBOUNCE_CNT+3 edges after key_n settles; key_long comes LONG_CNT+1 edges after key_press.
// Backpressure: none; one-cycle pulses with no flow control, so the consumer must sample them every cycle.
// Ports: sys_clk, sys_rst_n (async, active-low), key_n (raw, async, 0 = pressed), kif (key_ctrl_if.master outputs).
module key_ctrl #(
  parameter int unsigned DEBOUNCE_CNT = 999_999,
  parameter int unsigned LONG_CNT     = 49_999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        key_n,
  key_ctrl_if.master  kif
);

  localparam int DB_W   = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
  localparam int HOLD_W = (LONG_CNT > 0) ? $clog2(LONG_CNT + 1) : 1;
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CNT);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_LONG = 2'd2
  } state_t;

  logic              key_meta;
  logic              key_sync;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              key_level_q;
  logic              key_press_q;
  logic              key_release_q;
  logic              key_long_q;
  logic              blink_en_q;
  logic [1:0]        rate_sel_q;
  state_t            state;

  logic pressed_sync;
  logic db_commit;
  logic press_commit;
  logic release_commit;

  // Two-flop synchroniser; resets to "released" so a held key is re-debounced after reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
    end else begin
      key_meta <= key_n;
      key_sync <= key_meta;
    end
  end

  assign pressed_sync   = ~key_sync;
  // Commit is combinational so the FSM reacts on the same edge that key_level flips.
  assign db_commit      = (pressed_sync != key_level_q) && (db_cnt == DB_MAX);
  assign press_commit   = db_commit && pressed_sync;
  assign release_commit = db_commit && !pressed_sync;

  // Debounce: count consecutive cycles disagreeing with key_level; any agreement restarts the count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_cnt        <= '0;
      key_level_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      key_press_q   <= press_commit;
      key_release_q <= release_commit;
      if (pressed_sync == key_level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        db_cnt      <= '0;
        key_level_q <= pressed_sync;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Press classifier. Release is tested before the long threshold so a tie counts as a short press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      key_long_q <= 1'b0;
      blink_en_q <= 1'b1;
      rate_sel_q <= 2'd0;
    end else begin
      key_long_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (press_commit) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (release_commit) begin
            state      <= S_IDLE;
            blink_en_q <= ~blink_en_q;
          end else if (hold_cnt == HOLD_MAX) begin
            state      <= S_LONG;
            key_long_q <= 1'b1;
            rate_sel_q <= rate_sel_q + 2'd1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        S_LONG: begin
          // hold_cnt stays frozen here, so key_long cannot repeat within one press.
          if (release_commit) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign kif.key_level   = key_level_q;
  assign kif.key_press   = key_press_q;
  assign kif.key_release = key_release_q;
  assign kif.key_long    = key_long_q;
  assign kif.blink_en    = blink_en_q;
  assign kif.rate_sel    = rate_sel_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Purpose: directed stimulus for key_ctrl, checked every cycle against an event-timestamp model plus literal expectations.
// Latency: inputs change on the falling edge; outputs are compared on the falling edge.
// Backpressure: not applicable.
module tb_key_ctrl;
  localparam int DEB = 3;
  localparam int LNG = 10;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_n     = 1'b1;

  key_ctrl_if kif ();

  key_ctrl #(.DEBOUNCE_CNT(DEB), .LONG_CNT(LNG)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_n     (key_n),
    .kif       (kif)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int n_press  = 0;
  int n_release = 0;
  int n_long   = 0;
  bit done     = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the key is seen two edges late; the level flips once it has disagreed for DEB+1
  // edges in a row; a press is long if no release arrives by LNG+1 edges after the press.
  bit         m_s1, m_s2, m_level, m_press, m_release, m_long, m_blink, m_holding, m_longed;
  int         m_run, m_t, m_pt;
  logic [1:0] m_rate;

  task automatic model_reset();
    m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_run = 0;
    m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
    m_blink = 1'b1; m_rate = 2'd0; m_holding = 1'b0; m_longed = 1'b0;
    m_t = 0; m_pt = 0;
  endtask

  task automatic model_step();
    bit ps;
    bit commit;
    ps = !m_s2;
    commit = 1'b0;
    m_press = 1'b0; m_release = 1'b0; m_long = 1'b0;
    if (ps != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        commit = 1'b1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_t++;
    if (commit && ps) begin
      m_press = 1'b1; m_holding = 1'b1; m_longed = 1'b0; m_pt = m_t;
    end else if (commit && !ps) begin
      m_release = 1'b1;
      if (m_holding && !m_longed) m_blink = !m_blink;
      m_holding = 1'b0;
    end else if (m_holding && !m_longed && (m_t - m_pt == LNG + 1)) begin
      m_long = 1'b1; m_rate = m_rate + 2'd1; m_longed = 1'b1;
    end
    if (commit) m_level = ps;
    m_s2 = m_s1;
    m_s1 = key_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(posedge sys_clk);
    edge_n++;
  end

  // Pulse tallies sampled just after the edge so they are settled by the falling edge.
  initial forever begin
    @(posedge sys_clk);
    #1;
    if (kif.key_press)   n_press++;
    if (kif.key_release) n_release++;
    if (kif.key_long)    n_long++;
  end

  function automatic int dut_vec();
    return int'({kif.key_level, kif.key_press, kif.key_release, kif.key_long, kif.blink_en, kif.rate_sel});
  endfunction

  function automatic int model_vec();
    return int'({m_level, m_press, m_release, m_long, m_blink, m_rate});
  endfunction

  initial forever begin
    @(negedge sys_clk);
    if (sys_rst_n && !done) chk("cycle_outputs", dut_vec(), model_vec());
  end

  function automatic bit pulse_sel(input int which);
    case (which)
      0:       return kif.key_press;
      1:       return kif.key_release;
      default: return kif.key_long;
    endcase
  endfunction

  // Waits up to max_cyc falling edges for a pulse and checks the edge it appeared on.
  task automatic chk_pulse(input string name, input int which, input int max_cyc, input int exp_edge,
                           output int at);
    bit found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge sys_clk);
      if (pulse_sel(which)) begin
        found = 1'b1;
        at = edge_n;
      end
    end
    chk(name, at, exp_edge);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  int e0, p, at;
  int exp_rates[4] = '{1, 2, 3, 0};

  initial begin
    ticks(3);
    sys_rst_n = 1'b1;

    // Idle after reset.
    ticks(20);
    chk("idle_level", int'(kif.key_level), 0);
    chk("idle_blink", int'(kif.blink_en), 1);
    chk("idle_rate", int'(kif.rate_sel), 0);
    chk("idle_pulses", n_press + n_release + n_long, 0);

    // Short press.
    key_n = 1'b0; e0 = edge_n;
    chk_pulse("short_press_edge", 0, 20, e0 + 6, p);
    chk("short_level", int'(kif.key_level), 1);
    key_n = 1'b1; e0 = edge_n;
    chk_pulse("short_release_edge", 1, 20, e0 + 6, at);
    chk("short_blink", int'(kif.blink_en), 0);
    chk("short_no_long", n_long, 0);
    ticks(8);

    // Long press held 30 cycles.
    key_n = 1'b0; e0 = edge_n;
    chk_pulse("long_press_edge", 0, 20, e0 + 6, p);
    chk_pulse("long_pulse_edge", 2, 20, p + 11, at);
    chk("long_rate", int'(kif.rate_sel), 1);
    ticks(13);
    chk("long_once", n_long, 1);
    key_n = 1'b1; e0 = edge_n;
    chk_pulse("long_release_edge", 1, 20, e0 + 6, at);
    chk("long_blink_kept", int'(kif.blink_en), 0);
    ticks(5);

    // Bounce: 2-cycle glitches never commit.
    for (int i = 0; i < 10; i++) begin
      key_n = ~key_n;
      ticks(2);
    end
    chk("bounce_no_press", n_press, 2);
    chk("bounce_level", int'(kif.key_level), 0);
    key_n = 1'b0; e0 = edge_n;
    chk_pulse("bounce_press_edge", 0, 20, e0 + 6, p);
    ticks(5);
    chk("bounce_single_press", n_press, 3);
    key_n = 1'b1; e0 = edge_n;
    chk_pulse("bounce_release_edge", 1, 20, e0 + 6, at);
    chk("bounce_blink", int'(kif.blink_en), 1);

    // Fresh reset, then four long presses step rate_sel 1, 2, 3, 0.
    sys_rst_n = 1'b0;
    ticks(2);
    sys_rst_n = 1'b1;
    ticks(2);
    for (int i = 0; i < 4; i++) begin
      key_n = 1'b0; e0 = edge_n;
      chk_pulse("multi_press_edge", 0, 20, e0 + 6, p);
      chk_pulse("multi_long_edge", 2, 20, p + 11, at);
      chk("multi_rate", int'(kif.rate_sel), exp_rates[i]);
      key_n = 1'b1; e0 = edge_n;
      chk_pulse("multi_release_edge", 1, 20, e0 + 6, at);
      ticks(3);
    end
    chk("multi_long_count", n_long, 5);
    chk("multi_blink", int'(kif.blink_en), 1);

    // Release commit lands exactly on the long threshold edge: release wins.
    key_n = 1'b0; e0 = edge_n;
    chk_pulse("race_press_edge", 0, 20, e0 + 6, p);
    ticks(5);
    key_n = 1'b1;
    chk_pulse("race_release_edge", 1, 20, p + 11, at);
    ticks(3);
    chk("race_no_long", n_long, 5);
    chk("race_rate", int'(kif.rate_sel), 0);
    chk("race_blink", int'(kif.blink_en), 0);
    ticks(5);

    // Reset while in the long state with the key held.
    key_n = 1'b0; e0 = edge_n;
    chk_pulse("rst_press_edge", 0, 20, e0 + 6, p);
    chk_pulse("rst_long_edge", 2, 20, p + 11, at);
    ticks(3);
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", dut_vec(), 7'b0000100);
    ticks(3);
    sys_rst_n = 1'b1; e0 = edge_n;
    chk_pulse("rst_repress_edge", 0, 20, e0 + 6, p);
    chk("rst_rate_after", int'(kif.rate_sel), 0);
    key_n = 1'b1; e0 = edge_n;
    chk_pulse("rst_release_edge", 1, 20, e0 + 6, at);
    ticks(5);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
